// File: rtl/time_display_scan_if.sv
// Signal bundle between the timekeeping counters, the display scanner and the 7-segment pins.
interface time_display_scan_if;
    logic [7:0] hour;
    logic [7:0] minute;
    logic [7:0] second;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] dig_en;
    logic       frame;

    modport master (
        output hour, minute, second,
        input  seg, dp, dig_en, frame
    );

    modport slave (
        input  hour, minute, second,
        output seg, dp, dig_en, frame
    );
endinterface

// File: rtl/time_display_scan.sv
// Six-digit multiplexed 7-segment scanner for hh:mm:ss with per-frame subtract-by-ten BCD conversion.
// Define DISP_BLINK_EN to drive dp as a colon that blinks with the displayed second LSB.
module time_display_scan #(
    parameter int unsigned SCAN_DIV = 1000
) (
    input logic                clk,
    input logic                rst,
    time_display_scan_if.slave bus
);
    localparam logic [3:0]  CodeDash  = 4'd10;
    localparam logic [3:0]  CodeBlank = 4'd15;
    localparam logic [15:0] ScanLast  = 16'(SCAN_DIV - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StConv} conv_state_e;

    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        logic [6:0] pat;
        case (code)
            4'd0:    pat = 7'h3F;
            4'd1:    pat = 7'h06;
            4'd2:    pat = 7'h5B;
            4'd3:    pat = 7'h4F;
            4'd4:    pat = 7'h66;
            4'd5:    pat = 7'h6D;
            4'd6:    pat = 7'h7D;
            4'd7:    pat = 7'h07;
            4'd8:    pat = 7'h7F;
            4'd9:    pat = 7'h6F;
            4'd10:   pat = 7'h40;
            default: pat = 7'h00;
        endcase
        return pat;
    endfunction

    // Scan timing
    logic [15:0] scan_q, scan_d;
    logic [2:0]  idx_q, idx_d;
    logic        scan_tc, frame_start;

    assign scan_tc     = (scan_q == ScanLast);
    assign frame_start = scan_tc && (idx_q == 3'd5);

    always_comb begin
        scan_d = scan_tc ? 16'd0 : scan_q + 16'd1;
        idx_d  = idx_q;
        if (scan_tc) begin
            idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end
    end

    // Display path: outputs are decoded from next-state so dig_en and seg switch together
    logic [5:0][3:0] shadow_q, disp_q, disp_d;
    logic [6:0]      seg_q;
    logic [5:0]      dig_en_q;
    logic            frame_q;

    assign disp_d = frame_start ? shadow_q : disp_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_q   <= 16'd0;
            idx_q    <= 3'd0;
            disp_q   <= {6{CodeBlank}};
            seg_q    <= 7'h00;
            dig_en_q <= 6'b000001;
            frame_q  <= 1'b0;
        end else begin
            scan_q   <= scan_d;
            idx_q    <= idx_d;
            disp_q   <= disp_d;
            seg_q    <= seg_decode(disp_d[idx_d]);
            dig_en_q <= 6'b000001 << idx_d;
            frame_q  <= frame_start;
        end
    end

    assign bus.seg    = seg_q;
    assign bus.dig_en = dig_en_q;
    assign bus.frame  = frame_q;

    // Converter
    conv_state_e state_q, state_d;
    logic [1:0]  field_q;
    logic [7:0]  snap_s_q, snap_m_q, snap_h_q;
    logic [7:0]  work_q;
    logic [3:0]  tens_q;
    logic [7:0]  field_val;
    logic        do_load, do_sub, do_write;

    always_comb begin
        case (field_q)
            2'd0:    field_val = snap_s_q;
            2'd1:    field_val = snap_m_q;
            default: field_val = snap_h_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        do_load  = 1'b0;
        do_sub   = 1'b0;
        do_write = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (frame_start) state_d = StLoad;
            end
            StLoad: begin
                do_load = 1'b1;
                state_d = StConv;
            end
            StConv: begin
                // Out-of-range fields skip subtraction and write dashes straight away
                if (work_q >= 8'd10 && work_q < 8'd100) begin
                    do_sub = 1'b1;
                end else begin
                    do_write = 1'b1;
                    state_d  = (field_q == 2'd2) ? StIdle : StLoad;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            field_q  <= 2'd0;
            snap_s_q <= 8'd0;
            snap_m_q <= 8'd0;
            snap_h_q <= 8'd0;
            work_q   <= 8'd0;
            tens_q   <= 4'd0;
            shadow_q <= {6{CodeBlank}};
        end else begin
            if (frame_start) begin
                snap_s_q <= bus.second;
                snap_m_q <= bus.minute;
                snap_h_q <= bus.hour;
                field_q  <= 2'd0;
            end
            if (do_load) begin
                work_q <= field_val;
                tens_q <= 4'd0;
            end
            if (do_sub) begin
                work_q <= work_q - 8'd10;
                tens_q <= tens_q + 4'd1;
            end
            if (do_write) begin
                if (work_q >= 8'd100) begin
                    shadow_q[{field_q, 1'b0}] <= CodeDash;
                    shadow_q[{field_q, 1'b1}] <= CodeDash;
                end else begin
                    shadow_q[{field_q, 1'b0}] <= work_q[3:0];
                    shadow_q[{field_q, 1'b1}] <= tens_q;
                end
                field_q <= field_q + 2'd1;
            end
        end
    end

`ifdef DISP_BLINK_EN
    // Committed copy tracks the snapshot whose digits are being displayed, not the newest one
    logic sec_lsb_q, sec_lsb_d;
    logic dp_q;

    assign sec_lsb_d = frame_start ? snap_s_q[0] : sec_lsb_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sec_lsb_q <= 1'b0;
            dp_q      <= 1'b0;
        end else begin
            sec_lsb_q <= sec_lsb_d;
            dp_q      <= sec_lsb_d & ((idx_d == 3'd2) | (idx_d == 3'd4));
        end
    end

    assign bus.dp = dp_q;
`else
    assign bus.dp = 1'b0;
`endif
endmodule

// File: tb/tb_time_display_scan.sv
// Directed bench for time_display_scan: per-frame scoreboard of dig_en/seg/dp for each digit slot.
module tb_time_display_scan;
    localparam int unsigned ScanDiv = 40;
`ifdef DISP_BLINK_EN
    localparam bit Blink = 1'b1;
`else
    localparam bit Blink = 1'b0;
`endif

    typedef struct packed {
        logic [5:0] en;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;
    int   waited;

    logic [7:0] h_v, m_v, s_v;
    logic [3:0] pend [6];
    logic       pend_lsb;
    exp_t       sb_q [$];

    time_display_scan_if bus ();

    time_display_scan #(.SCAN_DIV(ScanDiv)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] seg_ref(input logic [3:0] c);
        case (c)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            4'd10: return 7'h40;
            default: return 7'h00;
        endcase
    endfunction

    // {tens, ones} display codes for one field
    function automatic logic [7:0] codes_of(input logic [7:0] v);
        logic [3:0] t, o;
        if (v >= 8'd100) begin
            t = 4'd10;
            o = 4'd10;
        end else begin
            t = 4'(v / 8'd10);
            o = 4'(v % 8'd10);
        end
        return {t, o};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        h_v = h;
        m_v = m;
        s_v = s;
        bus.hour   = h;
        bus.minute = m;
        bus.second = s;
    endtask

    task automatic pend_blank();
        for (int k = 0; k < 6; k++) pend[k] = 4'd15;
        pend_lsb = 1'b0;
    endtask

    task automatic pend_from_inputs();
        logic [7:0] c;
        c = codes_of(s_v); pend[0] = c[3:0]; pend[1] = c[7:4];
        c = codes_of(m_v); pend[2] = c[3:0]; pend[3] = c[7:4];
        c = codes_of(h_v); pend[4] = c[3:0]; pend[5] = c[7:4];
        pend_lsb = s_v[0];
    endtask

    task automatic push_expected();
        exp_t e;
        for (int k = 0; k < 6; k++) begin
            e.en  = 6'(1 << k);
            e.seg = seg_ref(pend[k]);
            e.dp  = Blink && (k == 2 || k == 4) && pend_lsb;
            sb_q.push_back(e);
        end
    endtask

    task automatic wait_frame(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.frame !== 1'b1 && n < 400);
        chk("frame_seen", 32'(bus.frame), 32'd1);
    endtask

    // Check one frame; optionally change inputs after slot chg has been sampled
    task automatic run_frame(input int exp_wait, input int chg,
                             input logic [7:0] nh, input logic [7:0] nm, input logic [7:0] ns);
        exp_t e;
        int   n;
        wait_frame(n);
        chk("frame_spacing", 32'(n), 32'(exp_wait));
        push_expected();
        pend_from_inputs();
        for (int k = 0; k < 6; k++) begin
            e = sb_q.pop_front();
            chk($sformatf("dig_en[slot%0d]", k), 32'(bus.dig_en), 32'(e.en));
            chk($sformatf("seg[slot%0d]", k), 32'(bus.seg), 32'(e.seg));
            chk($sformatf("dp[slot%0d]", k), 32'(bus.dp), 32'(e.dp));
            if (k == 0) begin
                @(negedge clk);
                chk("frame_one_cycle", 32'(bus.frame), 32'd0);
                repeat (ScanDiv - 1) @(negedge clk);
            end else if (k < 5) begin
                repeat (ScanDiv) @(negedge clk);
            end
            if (k == chg) set_in(nh, nm, ns);
        end
    endtask

    initial begin
        rst = 1'b1;
        set_in(8'd12, 8'd34, 8'd56);
        pend_blank();
        repeat (3) @(negedge clk);
        chk("rst_dig_en", 32'(bus.dig_en), 32'h01);
        chk("rst_seg", 32'(bus.seg), 32'h00);
        chk("rst_dp", 32'(bus.dp), 32'h0);
        chk("rst_frame", 32'(bus.frame), 32'h0);
        rst = 1'b0;

        // First frame 6*ScanDiv after release, blank; then 12:34:56
        run_frame(6 * ScanDiv, -1, 0, 0, 0);
        run_frame(ScanDiv, -1, 0, 0, 0);
        // Mid-frame change shows up two frame starts later
        run_frame(ScanDiv, 2, 8'd23, 8'd59, 8'd59);
        run_frame(ScanDiv, -1, 0, 0, 0);
        run_frame(ScanDiv, 3, 8'd99, 8'd0, 8'd100);
        run_frame(ScanDiv, -1, 0, 0, 0);
        // 99:00:100 -> 9 9 / 0 0 / dash dash
        run_frame(ScanDiv, 1, 8'd12, 8'd34, 8'd58);
        run_frame(ScanDiv, -1, 0, 0, 0);
        run_frame(ScanDiv, 4, 8'd12, 8'd34, 8'd59);
        run_frame(ScanDiv, -1, 0, 0, 0);
        run_frame(ScanDiv, -1, 0, 0, 0);

        // Reset pulse while the converter is busy
        wait_frame(waited);
        repeat (5) @(negedge clk);
        chk("pre_rst_seg", 32'(bus.seg), 32'h6F);
        rst = 1'b1;
        #1;
        chk("midrst_dig_en", 32'(bus.dig_en), 32'h01);
        chk("midrst_seg", 32'(bus.seg), 32'h00);
        chk("midrst_dp", 32'(bus.dp), 32'h0);
        chk("midrst_frame", 32'(bus.frame), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        pend_blank();
        run_frame(6 * ScanDiv, -1, 0, 0, 0);
        run_frame(ScanDiv, -1, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
